alu_exec_unit: RTL and testbench

Execute-stage unit of the single-cycle MIPS datapath. It merges three functions:
- ALU control decode: ALUOp plus funct gives a 4-bit ALU control code.
- 32-bit ALU: result, zero flag, signed-overflow flag.
- Branch-target adder: PC+4 plus the word-scaled sign-extended offset.

All results are registered on one clock and handed to the exception handler, data memory and PC mux.

---
 rtl/alu_exec_unit_if.sv | 60 ++++++
 rtl/alu_exec_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// -----------------------------------------------------------------------------
// alu_exec_unit_if
// Bundle between the decode stage and the execute-stage unit. The execute
// stage samples the operands and control on the master side and returns the
// registered ALU, flag and branch-target results.
//
// Parameters:
//   WIDTH          datapath width (operands, result, PC, offset)
// Signals (master drives -> slave samples):
//   in_valid       operands and control valid this cycle
//   alu_op [1:0]   main-control ALUOp
//   funct  [5:0]   instruction[5:0]
//   shamt  [4:0]   instruction[10:6] (shift amount, shift build only)
//   read_data1     operand A (rs)
//   data2          operand B (rt or sign-extended immediate)
//   pc_plus4       PC+4
//   offset         sign-extended 16-bit immediate
// Signals (slave drives -> master samples):
//   out_valid      registered results valid
//   alu_control    decoded 4-bit ALU control code
//   alu_out        ALU result
//   zero           alu_out == 0
//   overflow       signed overflow on ADD/SUB
//   illegal        unsupported funct under R-type
//   branch_target  pc_plus4 + (offset << 2)
// -----------------------------------------------------------------------------
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic [1:0]       alu_op;
  logic [5:0]       funct;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] read_data1;
  logic [WIDTH-1:0] data2;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] offset;

  logic             out_valid;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] alu_out;
  logic             zero;
  logic             overflow;
  logic             illegal;
  logic [WIDTH-1:0] branch_target;

  // Upstream side: issues operands, consumes results.
  modport master (
    output in_valid, alu_op, funct, shamt, read_data1, data2, pc_plus4, offset,
    input  out_valid, alu_control, alu_out, zero, overflow, illegal, branch_target
  );

  // Execute unit side: consumes operands, produces registered results.
  modport slave (
    input  in_valid, alu_op, funct, shamt, read_data1, data2, pc_plus4, offset,
    output out_valid, alu_control, alu_out, zero, overflow, illegal, branch_target
  );

endinterface

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
// Execute stage of the single-cycle MIPS datapath. In one clock it:
//   - decodes ALUOp + funct into a 4-bit ALU control code (flagging
//     unsupported R-type functs as illegal),
//   - runs the 32-bit ALU (result, zero flag, signed-overflow flag),
//   - forms the branch target pc_plus4 + (offset << 2).
// All results are registered; out_valid follows in_valid by one cycle. When
// in_valid is low the result registers hold and out_valid drops.
//
// Optional feature macro: ALU_SHIFT_EN
//   Defined   -> R-type functs 000000/000010/000011 decode to SLL/SRL/SRA
//                of data2 by shamt.
//   Undefined -> those functs are illegal and shamt is ignored.
//
// Ports:
//   clk   rising-edge system clock
//   rst   synchronous active-high reset; clears every output, beats in_valid
//   sif   alu_exec_unit_if.slave bundle (operands in, registered results out)
// -----------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  alu_exec_unit_if.slave  sif
);

  // ALU control codes.
  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_ADDU = 4'b0011;
  localparam logic [3:0] CTRL_SUBU = 4'b0100;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_SLTU = 4'b1000;
  localparam logic [3:0] CTRL_SLL  = 4'b1001;
  localparam logic [3:0] CTRL_SRL  = 4'b1010;
  localparam logic [3:0] CTRL_SRA  = 4'b1011;
  localparam logic [3:0] CTRL_NOR  = 4'b1100;
  localparam logic [3:0] CTRL_ILL  = 4'b1111;

  // ALUOp encodings from main control.
  localparam logic [1:0] OP_MEM   = 2'b00;
  localparam logic [1:0] OP_BEQ   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_ORI   = 2'b11;

  // R-type funct encodings.
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  // Returns {illegal, control code} for a given ALUOp/funct pair.
  function automatic logic [4:0] decode_ctrl(input logic [1:0] op, input logic [5:0] fn);
    logic [4:0] r;
    r = {1'b1, CTRL_ILL};
    case (op)
      OP_MEM:   r = {1'b0, CTRL_ADD};
      OP_BEQ:   r = {1'b0, CTRL_SUB};
      OP_ORI:   r = {1'b0, CTRL_OR};
      OP_RTYPE: begin
        case (fn)
          FN_AND:  r = {1'b0, CTRL_AND};
          FN_OR:   r = {1'b0, CTRL_OR};
          FN_ADD:  r = {1'b0, CTRL_ADD};
          FN_ADDU: r = {1'b0, CTRL_ADDU};
          FN_SUB:  r = {1'b0, CTRL_SUB};
          FN_SUBU: r = {1'b0, CTRL_SUBU};
          FN_SLT:  r = {1'b0, CTRL_SLT};
          FN_SLTU: r = {1'b0, CTRL_SLTU};
          FN_NOR:  r = {1'b0, CTRL_NOR};
`ifdef ALU_SHIFT_EN
          FN_SLL:  r = {1'b0, CTRL_SLL};
          FN_SRL:  r = {1'b0, CTRL_SRL};
          FN_SRA:  r = {1'b0, CTRL_SRA};
`endif
          default: r = {1'b1, CTRL_ILL};
        endcase
      end
      default:  r = {1'b1, CTRL_ILL};
    endcase
    return r;
  endfunction

  // Signed overflow of A+B: same-sign operands producing a different-sign sum.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  // Signed overflow of A-B: different-sign operands, result sign differs from A.
  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  logic [3:0]       ctrl_s;
  logic             illegal_s;
  logic [WIDTH-1:0] opa_s;
  logic [WIDTH-1:0] opb_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] result_s;
  logic             ovf_s;
  logic             zero_s;
  logic [WIDTH-1:0] target_s;

  logic             valid_d,   valid_q;
  logic [3:0]       ctrl_d,    ctrl_q;
  logic [WIDTH-1:0] result_d,  result_q;
  logic             zero_d,    zero_q;
  logic             ovf_d,     ovf_q;
  logic             illegal_d, illegal_q;
  logic [WIDTH-1:0] target_d,  target_q;

  assign opa_s = sif.read_data1;
  assign opb_s = sif.data2;
  assign sum_s  = opa_s + opb_s;
  assign diff_s = opa_s - opb_s;

  // Top two offset bits fall off the word scaling; shamt is only consumed by
  // the shift build.
  logic unused_inputs_s;
`ifdef ALU_SHIFT_EN
  assign unused_inputs_s = ^sif.offset[WIDTH-1:WIDTH-2];
`else
  assign unused_inputs_s = ^{sif.offset[WIDTH-1:WIDTH-2], sif.shamt};
`endif

  // Control decode.
  always_comb begin
    {illegal_s, ctrl_s} = decode_ctrl(sif.alu_op, sif.funct);
  end

  // ALU datapath: result selected by control code.
  always_comb begin
    result_s = {WIDTH{1'b0}};
    case (ctrl_s)
      CTRL_AND:  result_s = opa_s & opb_s;
      CTRL_OR:   result_s = opa_s | opb_s;
      CTRL_NOR:  result_s = ~(opa_s | opb_s);
      CTRL_ADD:  result_s = sum_s;
      CTRL_ADDU: result_s = sum_s;
      CTRL_SUB:  result_s = diff_s;
      CTRL_SUBU: result_s = diff_s;
      CTRL_SLT:  result_s = {{(WIDTH-1){1'b0}}, ($signed(opa_s) < $signed(opb_s))};
      CTRL_SLTU: result_s = {{(WIDTH-1){1'b0}}, (opa_s < opb_s)};
`ifdef ALU_SHIFT_EN
      CTRL_SLL:  result_s = opb_s << sif.shamt;
      CTRL_SRL:  result_s = opb_s >> sif.shamt;
      CTRL_SRA:  result_s = WIDTH'($signed(opb_s) >>> sif.shamt);
`endif
      default:   result_s = {WIDTH{1'b0}};
    endcase
  end

  // Overflow only for the trapping ADD/SUB codes; unsigned forms never flag.
  always_comb begin
    ovf_s = 1'b0;
    case (ctrl_s)
      CTRL_ADD: ovf_s = add_ovf(opa_s[WIDTH-1], opb_s[WIDTH-1], sum_s[WIDTH-1]);
      CTRL_SUB: ovf_s = sub_ovf(opa_s[WIDTH-1], opb_s[WIDTH-1], diff_s[WIDTH-1]);
      default:  ovf_s = 1'b0;
    endcase
  end

  assign zero_s   = (result_s == {WIDTH{1'b0}});
  assign target_s = sif.pc_plus4 + {sif.offset[WIDTH-3:0], 2'b00};

  // Next-state: load on valid input, otherwise hold results and drop valid.
  always_comb begin
    if (sif.in_valid) begin
      valid_d   = 1'b1;
      ctrl_d    = ctrl_s;
      result_d  = result_s;
      zero_d    = zero_s;
      ovf_d     = ovf_s;
      illegal_d = illegal_s;
      target_d  = target_s;
    end else begin
      valid_d   = 1'b0;
      ctrl_d    = ctrl_q;
      result_d  = result_q;
      zero_d    = zero_q;
      ovf_d     = ovf_q;
      illegal_d = illegal_q;
      target_d  = target_q;
    end
  end

  // Output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      ctrl_q    <= 4'b0000;
      result_q  <= {WIDTH{1'b0}};
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
      target_q  <= {WIDTH{1'b0}};
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      illegal_q <= illegal_d;
      target_q  <= target_d;
    end
  end

  assign sif.out_valid     = valid_q;
  assign sif.alu_control   = ctrl_q;
  assign sif.alu_out       = result_q;
  assign sif.zero          = zero_q;
  assign sif.overflow      = ovf_q;
  assign sif.illegal       = illegal_q;
  assign sif.branch_target = target_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit: directed cases plus randomized traffic, checked
// by a scoreboard queue filled at issue time and drained by a monitor.
module tb_alu_exec_unit;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        ill;
    logic [31:0] bt;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sbq[$];

  alu_exec_unit_if #(.WIDTH(32)) bus ();

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .sif (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: decode table and arithmetic straight from the ISA rules.
  function automatic exp_t model(input logic [1:0] op, input logic [5:0] fn,
                                 input logic [4:0] sh, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] pc,
                                 input logic [31:0] off);
    exp_t   e;
    longint sa;
    longint sb;
    longint s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.ill = 1'b0;
    e.ovf = 1'b0;
    e.res = 32'd0;
    if (op == 2'b00) e.ctrl = 4'd2;
    else if (op == 2'b01) e.ctrl = 4'd6;
    else if (op == 2'b11) e.ctrl = 4'd1;
    else begin
      case (fn)
        6'b100100: e.ctrl = 4'd0;
        6'b100101: e.ctrl = 4'd1;
        6'b100000: e.ctrl = 4'd2;
        6'b100001: e.ctrl = 4'd3;
        6'b100010: e.ctrl = 4'd6;
        6'b100011: e.ctrl = 4'd4;
        6'b101010: e.ctrl = 4'd7;
        6'b101011: e.ctrl = 4'd8;
        6'b100111: e.ctrl = 4'd12;
`ifdef ALU_SHIFT_EN
        6'b000000: e.ctrl = 4'd9;
        6'b000010: e.ctrl = 4'd10;
        6'b000011: e.ctrl = 4'd11;
`endif
        default: begin e.ctrl = 4'd15; e.ill = 1'b1; end
      endcase
    end
    case (e.ctrl)
      4'd0:  e.res = a & b;
      4'd1:  e.res = a | b;
      4'd12: e.res = ~(a | b);
      4'd2, 4'd3: e.res = a + b;
      4'd6, 4'd4: e.res = a - b;
      4'd7:  e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'd8:  e.res = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_SHIFT_EN
      4'd9:  e.res = b << sh;
      4'd10: e.res = b >> sh;
      4'd11: e.res = 32'(sb >> sh);
`endif
      default: e.res = 32'd0;
    endcase
    // Overflow: true mathematical result does not fit in 32 signed bits.
    if (e.ctrl == 4'd2) begin
      s = sa + sb;
      e.ovf = (s != longint'($signed(s[31:0])));
    end else if (e.ctrl == 4'd6) begin
      s = sa - sb;
      e.ovf = (s != longint'($signed(s[31:0])));
    end
    e.zero = (e.res == 32'd0);
    e.bt   = pc + off * 32'd4;
    if (sh == 5'd31) e.bt = e.bt; // shamt has no effect on the target
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs from just after a falling edge.
  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                       input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] off);
    bus.in_valid   = v;
    bus.alu_op     = op;
    bus.funct      = fn;
    bus.shamt      = sh;
    bus.read_data1 = a;
    bus.data2      = b;
    bus.pc_plus4   = pc;
    bus.offset     = off;
    if (v && !rst) sbq.push_back(model(op, fn, sh, a, b, pc, off));
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, $urandom_range(3, 0), 6'($urandom), 5'($urandom), $urandom, $urandom,
          $urandom, $urandom);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(7, 0))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [5:0] pick_funct();
    logic [5:0] tbl [13];
    tbl = '{6'b100100, 6'b100101, 6'b100000, 6'b100001, 6'b100010, 6'b100011,
            6'b101010, 6'b101011, 6'b100111, 6'b000000, 6'b000010, 6'b000011,
            6'b111111};
    if ($urandom_range(9, 0) == 0) return 6'($urandom);
    return tbl[$urandom_range(12, 0)];
  endfunction

  // Monitor: after every rising edge compare the DUT outputs with the
  // scoreboard; a new entry is popped whenever the DUT presents out_valid.
  initial begin : monitor
    exp_t last;
    logic s_rst;
    logic s_v;
    last.ctrl = 4'd0; last.res = 32'd0; last.zero = 1'b0;
    last.ovf = 1'b0;  last.ill = 1'b0;  last.bt = 32'd0;
    forever begin
      @(posedge clk);
      s_rst = rst;
      s_v   = bus.in_valid;
      #1;
      if (s_rst) begin
        last.ctrl = 4'd0; last.res = 32'd0; last.zero = 1'b0;
        last.ovf = 1'b0;  last.ill = 1'b0;  last.bt = 32'd0;
      end else if (bus.out_valid === 1'b1 && sbq.size() > 0) begin
        last = sbq.pop_front();
      end
      chk("out_valid",     {31'd0, bus.out_valid}, {31'd0, (!s_rst && s_v)});
      chk("alu_control",   {28'd0, bus.alu_control}, {28'd0, last.ctrl});
      chk("alu_out",       bus.alu_out, last.res);
      chk("zero",          {31'd0, bus.zero}, {31'd0, last.zero});
      chk("overflow",      {31'd0, bus.overflow}, {31'd0, last.ovf});
      chk("illegal",       {31'd0, bus.illegal}, {31'd0, last.ill});
      chk("branch_target", bus.branch_target, last.bt);
    end
  end

  // Stimulus.
  initial begin : stim
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.alu_op = 2'b10; bus.funct = 6'b100000; bus.shamt = 5'd0;
    bus.read_data1 = 32'h1234_5678; bus.data2 = 32'h1111_1111;
    bus.pc_plus4 = 32'h0000_0100; bus.offset = 32'h0000_0010;
    // Reset held for two edges with in_valid high.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    drive(1'b1, 2'b10, 6'b100000, 5'd0, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h0);
    drive(1'b1, 2'b10, 6'b100001, 5'd0, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h0);
    drive(1'b1, 2'b10, 6'b100010, 5'd0, 32'h8000_0000, 32'h1, 32'h0, 32'h0);
    drive(1'b1, 2'b01, 6'b000000, 5'd0, 32'h1234_5678, 32'h1234_5678, 32'h4, 32'h1);
    drive(1'b1, 2'b01, 6'b111111, 5'd0, 32'd5, 32'd3, 32'h8, 32'h2);
    drive(1'b1, 2'b10, 6'b101010, 5'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0);
    drive(1'b1, 2'b10, 6'b101011, 5'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0);
    drive(1'b1, 2'b10, 6'b100111, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    drive(1'b1, 2'b00, 6'b000000, 5'd0, 32'h10, 32'h20, 32'h0000_0104, 32'hFFFF_FFFE);
    drive(1'b1, 2'b11, 6'b000000, 5'd0, 32'hF0, 32'h0F, 32'hFFFF_FFFC, 32'h0000_0002);
    drive(1'b1, 2'b10, 6'b111111, 5'd3, 32'hDEAD_BEEF, 32'h1, 32'h40, 32'h3);
    idle();
    idle();

    // Randomized traffic, with a reset pulse (in_valid high) midway.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        rst = 1'b1;
        drive(1'b1, 2'b10, 6'b100000, 5'd0, $urandom, $urandom, $urandom, $urandom);
        rst = 1'b0;
      end
      drive($urandom_range(3, 0) != 0, 2'($urandom), pick_funct(), 5'($urandom),
            pick_operand(), pick_operand(), $urandom, pick_operand());
    end
    repeat (3) idle();

    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
